reg_file_seq: RTL and testbench

REG_FILE_SEQ -- requirements
Module: reg_file_seq

---
 rtl/reg_file_seq.sv | 206 ++++++++++++++++++++
 tb/tb_reg_file_seq.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_seq.sv
// reg_file_seq: four-state instruction sequencer in front of an external
// 8 x 16-bit register file. Each instruction walks IDLE -> READ -> EXEC ->
// WRITE, reads two source registers, runs a small ALU and writes the result
// back, retiring one instruction at most every four cycles.
module reg_file_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [2:0]  op,
   input  logic [2:0]  rd,
   input  logic [2:0]  rs1,
   input  logic [2:0]  rs2,
   input  logic [15:0] imm,
   output logic [2:0]  rf_rd_addr_a,
   output logic [2:0]  rf_rd_addr_b,
   input  logic [15:0] rf_d_out_a,
   input  logic [15:0] rf_d_out_b,
   output logic        rf_wr,
   output logic [2:0]  rf_wr_addr,
   output logic [15:0] rf_d_in,
   output logic        done,
   output logic [15:0] result,
   output logic        carry,
   output logic        zero,
   output logic [15:0] retired
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      EXEC  = 2'd2,
      WRITE = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_MOV = 3'b101,
      OP_LDI = 3'b110,
      OP_NOP = 3'b111
   } op_e;

   state_e      state;
   state_e      next_state;

   op_e         op_q;
   logic [2:0]  rd_q;
   logic [2:0]  rs1_q;
   logic [2:0]  rs2_q;
   logic [15:0] imm_q;

   logic [15:0] operand_a;
   logic [15:0] operand_b;

   logic [16:0] sum_full;
   logic [15:0] alu_result;
   logic        alu_carry;
   logic        alu_zero;

   logic        handshake;

   assign handshake = instr_valid && instr_ready;

   // State register; reset always lands in IDLE, abandoning any instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: one step per clock, only IDLE waits for an instruction.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (instr_valid) next_state = READ;
         READ:    next_state = EXEC;
         EXEC:    next_state = WRITE;
         WRITE:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Capture the instruction fields on the handshake; they stay frozen until the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q  <= OP_ADD;
         rd_q  <= 3'd0;
         rs1_q <= 3'd0;
         rs2_q <= 3'd0;
         imm_q <= 16'h0000;
      end else if (handshake) begin
         op_q  <= op_e'(op);
         rd_q  <= rd;
         rs1_q <= rs1;
         rs2_q <= rs2;
         imm_q <= imm;
      end
   end

   // Sample both register-file read ports while leaving READ.
   always_ff @(posedge clk) begin
      if (reset) begin
         operand_a <= 16'h0000;
         operand_b <= 16'h0000;
      end else if (state == READ) begin
         operand_a <= rf_d_out_a;
         operand_b <= rf_d_out_b;
      end
   end

   assign sum_full = {1'b0, operand_a} + {1'b0, operand_b};

   // ALU: NOP reproduces the current result and flags so nothing changes.
   always_comb begin
      alu_result = result;
      alu_carry  = carry;
      alu_zero   = zero;
      case (op_q)
         OP_ADD: begin
            alu_result = sum_full[15:0];
            alu_carry  = sum_full[16];
         end
         OP_SUB: begin
            alu_result = operand_a - operand_b;
            alu_carry  = (operand_a < operand_b);
         end
         OP_AND: begin
            alu_result = operand_a & operand_b;
            alu_carry  = 1'b0;
         end
         OP_OR: begin
            alu_result = operand_a | operand_b;
            alu_carry  = 1'b0;
         end
         OP_XOR: begin
            alu_result = operand_a ^ operand_b;
            alu_carry  = 1'b0;
         end
         OP_MOV: begin
            alu_result = operand_a;
            alu_carry  = 1'b0;
         end
         OP_LDI: begin
            alu_result = imm_q;
            alu_carry  = 1'b0;
         end
         default: begin
            alu_result = result;
            alu_carry  = carry;
         end
      endcase
      if (op_q != OP_NOP) begin
         alu_zero = (alu_result == 16'h0000);
      end
   end

   // Commit the ALU value and flags while leaving EXEC (skipped for NOP).
   always_ff @(posedge clk) begin
      if (reset) begin
         result <= 16'h0000;
         carry  <= 1'b0;
         zero   <= 1'b0;
      end else if ((state == EXEC) && (op_q != OP_NOP)) begin
         result <= alu_result;
         carry  <= alu_carry;
         zero   <= alu_zero;
      end
   end

   // Retirement counter, bumped once per instruction as WRITE ends; wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         retired <= 16'h0000;
      end else if (state == WRITE) begin
         retired <= retired + 16'd1;
      end
   end

   // Handshake, register-file and completion outputs; reset gates every strobe.
   always_comb begin
      instr_ready  = 1'b0;
      rf_rd_addr_a = 3'd0;
      rf_rd_addr_b = 3'd0;
      rf_wr        = 1'b0;
      rf_wr_addr   = rd_q;
      rf_d_in      = result;
      done         = 1'b0;
      if (state == IDLE) begin
         instr_ready = !reset;
      end else begin
         rf_rd_addr_a = rs1_q;
         rf_rd_addr_b = rs2_q;
      end
      if (state == WRITE) begin
         rf_wr = !reset && (op_q != OP_NOP);
         done  = !reset;
      end
   end

endmodule

// File: tb/tb_reg_file_seq.sv
// tb_reg_file_seq: drives reg_file_seq against a bench-side register file and
// an instruction-level model that tracks what each output must be per cycle.
module tb_reg_file_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  op;
   logic [2:0]  rd;
   logic [2:0]  rs1;
   logic [2:0]  rs2;
   logic [15:0] imm;
   logic [2:0]  rf_rd_addr_a;
   logic [2:0]  rf_rd_addr_b;
   logic [15:0] rf_d_out_a;
   logic [15:0] rf_d_out_b;
   logic        rf_wr;
   logic [2:0]  rf_wr_addr;
   logic [15:0] rf_d_in;
   logic        done;
   logic [15:0] result;
   logic        carry;
   logic        zero;
   logic [15:0] retired;

   int tests = 0;
   int fails = 0;

   logic check_en = 1'b0;
   logic cont_mode = 1'b0;
   int   cyc = 0;
   int   last_hs = -1;
   int   done_count = 0;
   int   wr_count = 0;

   // Register file owned by the bench and written only by the DUT.
   logic [15:0] rf_mem [8] = '{default: 16'h0000};

   // Instruction-level model state.
   logic [15:0] model_rf [8] = '{default: 16'h0000};
   logic        m_busy;
   int          m_phase;
   logic [2:0]  m_op;
   logic [2:0]  m_rd;
   logic [2:0]  m_rs1;
   logic [2:0]  m_rs2;
   logic [15:0] m_val;
   logic        m_c;
   logic [15:0] m_result;
   logic        m_carry;
   logic        m_zero;
   logic [15:0] m_retired;

   always #5 clk = ~clk;

   reg_file_seq dut (
      .clk          (clk),
      .reset        (reset),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .op           (op),
      .rd           (rd),
      .rs1          (rs1),
      .rs2          (rs2),
      .imm          (imm),
      .rf_rd_addr_a (rf_rd_addr_a),
      .rf_rd_addr_b (rf_rd_addr_b),
      .rf_d_out_a   (rf_d_out_a),
      .rf_d_out_b   (rf_d_out_b),
      .rf_wr        (rf_wr),
      .rf_wr_addr   (rf_wr_addr),
      .rf_d_in      (rf_d_in),
      .done         (done),
      .result       (result),
      .carry        (carry),
      .zero         (zero),
      .retired      (retired)
   );

   assign rf_d_out_a = rf_mem[rf_rd_addr_a];
   assign rf_d_out_b = rf_mem[rf_rd_addr_b];

   // Register file write port.
   always @(posedge clk) begin
      if (rf_wr) rf_mem[rf_wr_addr] <= rf_d_in;
   end

   // Architectural effect of one instruction: {carry, value}.
   function automatic logic [16:0] alu_model(input logic [2:0] o, input logic [15:0] a,
                                             input logic [15:0] b, input logic [15:0] im);
      int unsigned s;
      case (o)
         3'd0: begin
            s = a + b;
            return {s[16], s[15:0]};
         end
         3'd1: return {(a < b), 16'(a - b)};
         3'd2: return {1'b0, a & b};
         3'd3: return {1'b0, a | b};
         3'd4: return {1'b0, a ^ b};
         3'd5: return {1'b0, a};
         3'd6: return {1'b0, im};
         default: return 17'h0;
      endcase
   endfunction

   // Model: an accepted instruction is evaluated against model_rf immediately,
   // its flags become visible 2 edges later and its write/retire 3 edges later.
   always @(posedge clk) begin
      if (reset) begin
         m_busy    <= 1'b0;
         m_phase   <= 0;
         m_result  <= 16'h0000;
         m_carry   <= 1'b0;
         m_zero    <= 1'b0;
         m_retired <= 16'h0000;
      end else if (!m_busy) begin
         if (instr_valid) begin
            m_busy  <= 1'b1;
            m_phase <= 1;
            m_op    <= op;
            m_rd    <= rd;
            m_rs1   <= rs1;
            m_rs2   <= rs2;
            {m_c, m_val} <= alu_model(op, model_rf[rs1], model_rf[rs2], imm);
         end
      end else begin
         m_phase <= m_phase + 1;
         if (m_phase == 2 && m_op != 3'd7) begin
            m_result <= m_val;
            m_carry  <= m_c;
            m_zero   <= (m_val == 16'h0000);
         end
         if (m_phase == 3) begin
            if (m_op != 3'd7) model_rf[m_rd] <= m_val;
            m_retired <= m_retired + 16'd1;
            m_busy    <= 1'b0;
            m_phase   <= 0;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      logic exp_wr;
      if (check_en) begin
         exp_wr = m_busy && (m_phase == 3) && (m_op != 3'd7) && !reset;
         checkOutput("instr_ready", 32'(instr_ready), 32'(!m_busy && !reset));
         checkOutput("rf_wr", 32'(rf_wr), 32'(exp_wr));
         checkOutput("done", 32'(done), 32'(m_busy && (m_phase == 3) && !reset));
         checkOutput("rf_rd_addr_a", 32'(rf_rd_addr_a), 32'(m_busy ? m_rs1 : 3'd0));
         checkOutput("rf_rd_addr_b", 32'(rf_rd_addr_b), 32'(m_busy ? m_rs2 : 3'd0));
         if (exp_wr) begin
            checkOutput("rf_wr_addr", 32'(rf_wr_addr), 32'(m_rd));
            checkOutput("rf_d_in", 32'(rf_d_in), 32'(m_val));
         end
         checkOutput("result", 32'(result), 32'(m_result));
         checkOutput("carry", 32'(carry), 32'(m_carry));
         checkOutput("zero", 32'(zero), 32'(m_zero));
         checkOutput("retired", 32'(retired), 32'(m_retired));
         for (int i = 0; i < 8; i++) begin
            checkOutput("regfile", {13'h0, 3'(i), rf_mem[i]}, {13'h0, 3'(i), model_rf[i]});
         end
      end
   end

   // Handshake spacing and strobe counters.
   always @(negedge clk) begin
      cyc++;
      if (done) done_count++;
      if (rf_wr) wr_count++;
      if (!cont_mode) begin
         last_hs = -1;
      end else if (instr_valid && instr_ready && !reset) begin
         if (last_hs >= 0) checkOutput("hs_spacing", 32'(cyc - last_hs), 32'd4);
         last_hs = cyc;
      end
   end

   // Offer one instruction and return just after the edge that accepts it.
   task automatic applyStimulus(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s1,
                                input logic [2:0] s2, input logic [15:0] im);
      logic got;
      got = 1'b0;
      @(posedge clk);
      #2;
      op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
      instr_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (instr_ready) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput("handshake_seen", 32'(got), 32'd1);
      @(posedge clk);
      #2;
      instr_valid = 1'b0;
      op = 3'($urandom); rd = 3'($urandom); rs1 = 3'($urandom); rs2 = 3'($urandom);
      imm = 16'($urandom);
   endtask

   // Wait (bounded) until the sequencer is idle again.
   task automatic waitIdle();
      logic got;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (instr_ready) begin
            got = 1'b1;
            break;
         end
      end
      checkOutput("idle_seen", 32'(got), 32'd1);
   endtask

   task automatic runOne(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [15:0] im);
      applyStimulus(o, d, s1, s2, im);
      waitIdle();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int done_start;
      int wr_start;
      int ret_start;
      reset = 1'b1; instr_valid = 1'b0;
      op = 3'd0; rd = 3'd0; rs1 = 3'd0; rs2 = 3'd0; imm = 16'h0;

      @(posedge clk);
      #1 check_en = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_ready", 32'(instr_ready), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", 32'(result), 32'd0);
      checkOutput("reset_retired", 32'(retired), 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;

      // LDI/LDI/ADD without carry.
      runOne(3'd6, 3'd0, 3'd0, 3'd0, 16'h1234);
      runOne(3'd6, 3'd1, 3'd0, 3'd0, 16'h5678);
      runOne(3'd0, 3'd2, 3'd0, 3'd1, 16'h0000);
      checkOutput("add_r2", 32'(rf_mem[2]), 32'h68AC);
      checkOutput("model_r2", 32'(model_rf[2]), 32'h68AC);
      checkOutput("add_carry", 32'(carry), 32'd0);
      checkOutput("add_zero", 32'(zero), 32'd0);
      checkOutput("add_retired", 32'(retired), 32'd3);

      // Carry-out and zero, then SUB with borrow.
      runOne(3'd6, 3'd3, 3'd0, 3'd0, 16'hFFFF);
      runOne(3'd6, 3'd4, 3'd0, 3'd0, 16'h0001);
      runOne(3'd0, 3'd5, 3'd3, 3'd4, 16'h0000);
      checkOutput("addc_r5", 32'(rf_mem[5]), 32'h0000);
      checkOutput("addc_carry", 32'(carry), 32'd1);
      checkOutput("addc_zero", 32'(zero), 32'd1);
      runOne(3'd1, 3'd6, 3'd4, 3'd3, 16'h0000);
      checkOutput("sub_r6", 32'(rf_mem[6]), 32'h0002);
      checkOutput("model_r6", 32'(model_rf[6]), 32'h0002);
      checkOutput("sub_borrow", 32'(carry), 32'd1);
      checkOutput("sub_zero", 32'(zero), 32'd0);

      // NOP leaves flags alone, still pulses done and retires.
      done_start = done_count;
      wr_start = wr_count;
      runOne(3'd7, 3'd6, 3'd1, 3'd2, 16'hBEEF);
      checkOutput("nop_done", 32'(done_count - done_start), 32'd1);
      checkOutput("nop_wr", 32'(wr_count - wr_start), 32'd0);
      checkOutput("nop_result", 32'(result), 32'h0002);
      checkOutput("nop_carry", 32'(carry), 32'd1);
      checkOutput("nop_retired", 32'(retired), 32'd8);
      checkOutput("nop_r6", 32'(rf_mem[6]), 32'h0002);

      // XOR of a register with itself.
      runOne(3'd6, 3'd0, 3'd0, 3'd0, 16'hDEF0);
      runOne(3'd4, 3'd0, 3'd0, 3'd0, 16'h0000);
      checkOutput("xor_r0", 32'(rf_mem[0]), 32'h0000);
      checkOutput("xor_zero", 32'(zero), 32'd1);
      checkOutput("xor_carry", 32'(carry), 32'd0);

      // Reset during EXEC of LDI r7, then accept right after reset releases.
      applyStimulus(3'd6, 3'd7, 3'd0, 3'd0, 16'h9ABC);
      @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #2;
      op = 3'd6; rd = 3'd1; rs1 = 3'd0; rs2 = 3'd0; imm = 16'h0BAD;
      instr_valid = 1'b1;
      @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      checkOutput("post_reset_ready", 32'(instr_ready), 32'd1);
      checkOutput("post_reset_retired", 32'(retired), 32'd0);
      checkOutput("r7_not_written", 32'(rf_mem[7]), 32'h0000);
      @(posedge clk);
      #2 instr_valid = 1'b0;
      waitIdle();
      checkOutput("post_reset_r1", 32'(rf_mem[1]), 32'h0BAD);
      checkOutput("post_reset_retired1", 32'(retired), 32'd1);

      // Valid held high with fields changing every cycle.
      done_start = done_count;
      ret_start = int'(retired);
      @(posedge clk);
      #2;
      cont_mode = 1'b1;
      instr_valid = 1'b1;
      for (int n = 0; n < 120; n++) begin
         op = 3'($urandom); rd = 3'($urandom); rs1 = 3'($urandom); rs2 = 3'($urandom);
         imm = 16'($urandom);
         @(posedge clk);
         #2;
      end
      instr_valid = 1'b0;
      waitIdle();
      cont_mode = 1'b0;
      checkOutput("cont_done_vs_retired", 32'(done_count - done_start),
                  32'(int'(retired) - ret_start));
      checkOutput("cont_retired_count", 32'(int'(retired) - ret_start), 32'd30);

      // Random valid, random fields and sporadic resets.
      for (int n = 0; n < 400; n++) begin
         @(posedge clk);
         #2;
         reset = ($urandom_range(0, 39) == 0);
         instr_valid = 1'($urandom_range(0, 1));
         op = 3'($urandom); rd = 3'($urandom); rs1 = 3'($urandom); rs2 = 3'($urandom);
         imm = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      end
      @(posedge clk);
      #2;
      reset = 1'b0;
      instr_valid = 1'b0;
      waitIdle();
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
